// File: rtl/motor_pkg.sv
// Shared types and helpers for the H-bridge PWM driver: drive modes,
// per-channel FSM states and counter range helpers.
package motor_pkg;

    typedef enum logic [1:0] {
        COAST = 2'b00,
        FWD   = 2'b01,
        REV   = 2'b10,
        BRAKE = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        S_COAST,
        S_FWD,
        S_REV,
        S_BRAKE,
        S_DEAD
    } ch_state_t;

    localparam int unsigned DEFAULT_CW = 8;

    function automatic int unsigned cnt_max(input int unsigned cw);
        return (32'd1 << cw) - 32'd1;
    endfunction

    function automatic ch_state_t mode_to_state(input mode_t m);
        case (m)
            COAST:   return S_COAST;
            FWD:     return S_FWD;
            REV:     return S_REV;
            default: return S_BRAKE;
        endcase
    endfunction

endpackage

// File: rtl/hbridge_ch.sv
// One H-bridge channel: shadowed duty/mode, drive FSM with dead-time
// insertion on mode changes, PWM compare and registered gate outputs.
module hbridge_ch
    import motor_pkg::*;
#(
    parameter int unsigned CW       = 8,
    parameter int unsigned DEAD_CYC = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_enable,
    input  logic          i_pe,
    input  logic [CW-1:0] i_cnt,
    input  logic [CW-1:0] i_duty,
    input  logic [1:0]    i_mode,
    output logic          o_a,
    output logic          o_b,
    output logic          o_dead_busy
);

    localparam int unsigned   DT_INIT = (DEAD_CYC > 0) ? DEAD_CYC - 1 : 0;
    localparam logic [CW-1:0] DT_LOAD = DT_INIT[CW-1:0];
    localparam bit            NO_DEAD = (DEAD_CYC == 0);

    ch_state_t     r_state;
    mode_t         r_pend;
    logic [CW-1:0] r_duty;
    logic [CW-1:0] r_dtmr;
    logic          r_a;
    logic          r_b;
    logic          r_db;

    mode_t         w_new_mode;
    ch_state_t     w_new_state;
    mode_t         w_pend_eff;
    logic          w_on;

    assign w_new_mode  = mode_t'(i_mode);
    assign w_new_state = mode_to_state(w_new_mode);
    // A boundary inside dead time replaces the pending mode in the same cycle.
    assign w_pend_eff  = i_pe ? w_new_mode : r_pend;
    assign w_on        = (r_duty == '1) || (i_cnt < r_duty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_COAST;
            r_pend  <= COAST;
            r_duty  <= '0;
            r_dtmr  <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_db    <= 1'b0;
        end else if (!i_enable) begin
            r_state <= S_COAST;
            r_dtmr  <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_db    <= 1'b0;
        end else begin
            if (i_pe) r_duty <= i_duty;
            r_a  <= ((r_state == S_FWD) && w_on) || (r_state == S_BRAKE);
            r_b  <= ((r_state == S_REV) && w_on) || (r_state == S_BRAKE);
            r_db <= (r_state == S_DEAD);
            case (r_state)
                S_DEAD: begin
                    if (r_dtmr != '0) r_dtmr <= r_dtmr - 1'b1;
                    if (i_pe) r_pend <= w_new_mode;
                    if (i_pe && (w_new_mode == COAST)) r_state <= S_COAST;
                    else if (r_dtmr == '0)             r_state <= mode_to_state(w_pend_eff);
                end
                default: begin
                    if (i_pe && (w_new_state != r_state)) begin
                        if ((w_new_mode == COAST) || NO_DEAD) begin
                            r_state <= w_new_state;
                        end else begin
                            r_state <= S_DEAD;
                            r_pend  <= w_new_mode;
                            r_dtmr  <= DT_LOAD;
                        end
                    end
                end
            endcase
        end
    end

    assign o_a         = r_a;
    assign o_b         = r_b;
    assign o_dead_busy = r_db;

endmodule

// File: rtl/hbridge_pwm_ctrl.sv
// Multi-channel H-bridge PWM driver: shared period counter and boundary
// pulse feeding NCH independent channel controllers.
module hbridge_pwm_ctrl
    import motor_pkg::*;
#(
    parameter int unsigned NCH      = 2,
    parameter int unsigned CW       = DEFAULT_CW,
    parameter int unsigned DEAD_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NCH*CW-1:0] duty_in,
    input  logic [NCH*2-1:0]  mode_in,
    output logic [NCH-1:0]    pwm_a,
    output logic [NCH-1:0]    pwm_b,
    output logic              period_start,
    output logic [NCH-1:0]    dead_busy
);

    localparam int unsigned   MAX_I   = cnt_max(CW);
    localparam logic [CW-1:0] CNT_MAX = MAX_I[CW-1:0];

    logic [CW-1:0] r_cnt;
    logic          r_ps;
    logic          w_pe;

    assign w_pe = enable && (r_cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_ps  <= 1'b0;
        end else begin
            r_cnt <= enable ? r_cnt + 1'b1 : '0;
            r_ps  <= w_pe;
        end
    end

    assign period_start = r_ps;

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_ch
            hbridge_ch #(
                .CW       (CW),
                .DEAD_CYC (DEAD_CYC)
            ) u_ch (
                .clk         (clk),
                .rst         (rst),
                .i_enable    (enable),
                .i_pe        (w_pe),
                .i_cnt       (r_cnt),
                .i_duty      (duty_in[g*CW +: CW]),
                .i_mode      (mode_in[g*2 +: 2]),
                .o_a         (pwm_a[g]),
                .o_b         (pwm_b[g]),
                .o_dead_busy (dead_busy[g])
            );
        end
    endgenerate

endmodule
